// File: rtl/ripple_adder_8_if.sv
// Operand/result bundle for the 8-bit ripple adder: the master drives operands, the slave returns results.
interface ripple_adder_8_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/ripple_adder_8.sv
// 8-bit ripple-carry adder, one full-adder cell per bit; sum/cout registered, 1-cycle latency.
// No backpressure: a new result is captured on every clock edge.
module ripple_adder_8 (
    input  logic             clk,
    input  logic             rst,
    ripple_adder_8_if.slave  bus
);

    logic [8:0] c;
    logic [7:0] s;

    assign c[0] = bus.cin;

    // Explicit cell per bit so the carry chain stays a true ripple.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_fa
            logic p;
            assign p        = bus.a[i] ^ bus.b[i];
            assign s[i]     = p ^ c[i];
            assign c[i + 1] = (bus.a[i] & bus.b[i]) | (c[i] & p);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum  <= 8'h00;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= s;
            bus.cout <= c[8];
        end
    end

endmodule

// File: tb/tb_ripple_adder_8.sv
// Directed and random-stream bench for ripple_adder_8 with an a+b+cin reference.
module tb_ripple_adder_8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ripple_adder_8_if bus ();

    ripple_adder_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] expected);
        logic [8:0] observed;
        observed = {bus.cout, bus.sum};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_q;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(8'($urandom), 8'($urandom), 1'($urandom));
        #1;
        check("reset_initial", 9'h000);

        for (int k = 0; k < 4; k++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            check("reset_hold", 9'h000);
        end

        rst = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        tick();
        check("zero_add", 9'h000);

        drive(8'hF0, 8'h0F, 1'b0);
        tick();
        check("complement_cin0", 9'h0FF);

        drive(8'hF0, 8'h0F, 1'b1);
        tick();
        check("complement_cin1", 9'h100);

        drive(8'h19, 8'h0B, 1'b1);
        #3;
        check("hold_before_edge", 9'h100);
        drive(8'h19, 8'h0B, 1'b1);
        tick();
        check("mixed_add", 9'h025);

        drive(8'hFF, 8'hFF, 1'b1);
        tick();
        check("max_result", 9'h1FF);

        drive(8'hFF, 8'h01, 1'b0);
        tick();
        check("wrap_ff_01", 9'h100);

        drive(8'h80, 8'h80, 1'b0);
        tick();
        check("msb_carry", 9'h100);

        drive(8'h33, 8'h44, 1'b0);
        tick();
        check("no_carry", 9'h077);

        drive(8'hF0, 8'h0F, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("midop_reset_immediate", 9'h000);
        tick();
        check("midop_reset_held", 9'h000);
        rst = 1'b0;
        #3;
        check("after_release_no_stale", 9'h000);
        tick();
        check("after_release_capture", 9'h100);

        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        drive(ra, rb, rc);
        exp_q = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
        for (int k = 0; k < 1000; k++) begin
            tick();
            check("stream", exp_q);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            exp_q = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_adder_8.md
Name: ripple_adder_8

Overview:
8-bit binary adder built as a chain of eight full-adder cells. Carry ripples from bit 0 to bit 7. The combinational sum and carry-out are captured in output registers, so results are presented synchronously to the surrounding datapath. It is a leaf arithmetic block used wherever an 8-bit add with carry-in/carry-out is needed.

Parameters:
None. Width is fixed at 8 bits.

Ports:
clk   input   1  system clock; all state updates on the rising edge
rst   input   1  asynchronous reset, active-high
a     input   8  addend A, unsigned; bit 7 is MSB
b     input   8  addend B, unsigned; bit 7 is MSB
cin   input   1  carry into bit 0
sum   output  8  registered sum bits {s7..s0}
cout  output  1  registered carry out of bit 7

Interface decision: one clock; reset is asynchronous and active-high. The clock is named clk and the reset is named rst.

Behaviour:
- Structure:
  - Eight full-adder cells, FA0..FA7.
  - FAi takes a[i], b[i] and c[i]; c[0] = cin.
  - FAi produces s[i] = a[i] ^ b[i] ^ c[i].
  - FAi produces c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - c[8] is the carry-out.
- No carry-lookahead or behavioural "+" is used for the add. The ripple chain must be explicit, cell per bit.
- Arithmetic: {c[8], s[7:0]} = a + b + cin, computed as a 9-bit unsigned result. There is no saturation; results wrap modulo 256 and the overflow appears on cout.
- Registering:
  - On each rising edge of clk with rst low: sum <= s[7:0] and cout <= c[8].
  - Latency is 1 cycle from the inputs to the outputs.
  - A new result is produced every cycle (throughput 1/cycle).
  - There is no enable and no handshake; the outputs always reflect the inputs sampled at the last edge.
- Reset:
  - When rst rises, sum = 8'h00 and cout = 0 immediately, without waiting for a clock edge.
  - The outputs hold these values while rst is high, regardless of a, b and cin.
  - The first capture after reset occurs on the first rising clk edge with rst low.
  - Reset asserted in the middle of operation discards the pending result. No stale value reappears after release.
- Inputs are sampled only at the clock edge. Changes between edges have no effect on the outputs.
- Boundary cases:
  - a=FF, b=FF, cin=1 gives sum=FF, cout=1. This is the maximum result, 0x1FF.
  - a=00, b=00, cin=0 gives sum=00, cout=0.
  - Full propagate (a^b=FF) with cin=1 must ripple through all 8 stages. The combinational path FA0->FA7 must settle within one clock period.
- There is no signed-overflow output. Signed interpretation is the consumer's responsibility.

Test Plan:
1. Reset: rst=1 with random a, b and cin, clock running -> sum=00, cout=0 throughout. Release rst, drive a=00, b=00, cin=0 -> sum=00, cout=0 after 1 edge.
2. Complementary operands: a=F0, b=0F, cin=0 -> after next edge sum=FF, cout=0. Then cin=1 -> sum=00, cout=1, confirming full 8-bit ripple.
3. Mixed add with carry-in: a=19, b=0B, cin=1 -> sum=25, cout=0. The result is 1 cycle later, and the outputs hold the prior value until that edge.
4. Extremes: a=FF, b=FF, cin=1 -> sum=FF, cout=1. a=FF, b=01, cin=0 -> sum=00, cout=1. a=80, b=80, cin=0 -> sum=00, cout=1.
5. Mid-operation reset: apply a=F0, b=0F, cin=1, then assert rst between edges -> sum=00, cout=0 immediately. After release with the inputs unchanged, the next edge gives sum=00, cout=1.
6. Back-to-back streaming: 1000 random {a, b, cin} vectors, one per cycle -> each cycle's {cout, sum} equals the previous cycle's a+b+cin. Compare against a 9-bit reference model.
